cpu_memory_responder: RTL and testbench
=======================================

# cpu_memory_responder

Memory-side responder for the pipelined MIPS CPU. It serves the CPU's instruction-fetch port (Pc → Inst) and data port (MemAdr/MemWriteData/MemoryRead/MemoryWrite → MemReadData) from two on-chip word arrays. After reset it runs a boot sequence: it streams a program into instruction memory through a ready/valid loader port, then zero-clears data memory, and only then releases the CPU from reset. It sits beside the CPU at the top level, and the loader port connects to the testbench or a host link.

## Interface
- IMEM_WORDS, 256: instruction memory depth in 32-bit words (power of two).
- DMEM_WORDS, 256: data memory depth in 32-bit words (power of two).
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- Pc  in  32  CPU fetch byte address.
- Inst  out  32  instruction word for Pc.
- MemAdr  in  32  CPU data byte address.
- MemWriteData  in  32  store data.
- MemoryRead  in  1  load request.
- MemoryWrite  in  1  store request.
- MemReadData  out  32  load data.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  marks the final loader word, qualified by ld_valid.
- ld_ready  out  1  loader can accept a word.
- cpu_rst  out  1  active-high reset to the CPU's rst.
- misalign_err  out  1  sticky flag for a misaligned data access.
- err_adr  out  32  MemAdr of the first misaligned access.

## Operation
- The FSM has three states: LOAD, CLEAR and RUN. Asserting rst forces LOAD from any state.
- **LOAD**
  - ld_ready=1.
  - A word is accepted when ld_valid&&ld_ready at a clk edge: imem[ld_ptr]<=ld_data, then ld_ptr<=ld_ptr+1.
  - Go to CLEAR when the accepted word has ld_last=1, or when it is written at ld_ptr=IMEM_WORDS-1 (the array is full).
  - Words that are never loaded keep their previous contents.
- **CLEAR**
  - ld_ready=0.
  - dmem[clr_ptr]<=0 and clr_ptr++ on each cycle, starting at 0.
  - After writing index DMEM_WORDS-1, go to RUN.
- **RUN**
  - ld_ready=0, and the loader inputs are ignored. RUN is terminal until reset.
  - Inst = imem[Pc[2+:log2(IMEM_WORDS)]], combinational. Upper Pc bits are ignored, so addresses alias. Pc[1:0] is ignored.
  - Data index = MemAdr[2+:log2(DMEM_WORDS)]. Upper bits alias.
  - Load: with MemoryRead=1 and MemAdr[1:0]=0, MemReadData = dmem[index], combinational. Otherwise MemReadData=0.
  - Store: with MemoryWrite=1 and MemAdr[1:0]=0, dmem[index]<=MemWriteData at the next clk edge.
  - MemoryRead and MemoryWrite both high: the store occurs at the edge, and MemReadData shows the old word during that cycle.
  - Misaligned access (MemoryRead or MemoryWrite with MemAdr[1:0]!=0):
    - The store is suppressed and the read returns 0.
    - misalign_err<=1. If it was previously 0, err_adr<=MemAdr.
    - Later errors do not overwrite err_adr.
- **cpu_rst**: 1 in LOAD and CLEAR, 0 in RUN. It is registered, i.e. decoded from the state register.
- **Outside RUN**: Inst=0 and MemReadData=0, and CPU data requests are ignored.

## Timing
- **Reset values**: state=LOAD, ld_ptr=0, clr_ptr=0, ld_ready=1, cpu_rst=1, Inst=0, MemReadData=0, misalign_err=0, err_adr=0.
- **Reset is asynchronous and active-low**:
  - Outputs take their reset values immediately when rst falls, independent of clk.
  - Memory array contents are not reset.
  - Reset asserted during LOAD, CLEAR or RUN restarts loading at ld_ptr=0.
- **Load to run**:
  - If the ld_last word is accepted at edge T, the state is CLEAR after T.
  - The state is RUN after edge T+DMEM_WORDS.
  - cpu_rst falls in the same cycle that RUN begins.
- **Load throughput**: one word per cycle. No bubbles are required between words.
- **Store latency**: the write lands at the edge where MemoryWrite is sampled. A load of the same address in the next cycle returns the new data.
- **Fetch and load latency**: zero cycles (combinational), matching a single-cycle MEM/IF stage.

## Test plan
- **Load and release**:
  - Stimulus: stream 4 words 0x20080005, 0x20090007, 0x01095020, 0xAC0A0000 with ld_last on the 4th, then DMEM_WORDS=256.
  - Required: cpu_rst falls exactly 256 cycles after the last acceptance.
  - Required: with Pc=8, Inst=0x01095020.
- **Full-array termination**: stream IMEM_WORDS words with ld_last=0 throughout. Required: transition to CLEAR after word IMEM_WORDS-1, and ld_ready=0 from then on.
- **Store then load**:
  - Stimulus in RUN: MemoryWrite with MemAdr=0x10 and MemWriteData=0xDEADBEEF, then the next cycle MemoryRead with MemAdr=0x10.
  - Required: MemReadData=0xDEADBEEF. An unwritten address returns 0 because of CLEAR.
- **Simultaneous read/write**:
  - Stimulus: dmem[4]=0x11, then MemoryRead=MemoryWrite=1 at MemAdr=0x10 with data 0x22.
  - Required: MemReadData=0x11 that cycle and 0x22 the next cycle.
- **Misaligned access**:
  - Stimulus: a store at MemAdr=0x12, then a load at MemAdr=0x21.
  - Required: misalign_err=1, err_adr=0x12, dmem[4] unchanged, and MemReadData=0 for the load.
- **Reset mid-CLEAR**:
  - Stimulus: drop rst 10 cycles into CLEAR.
  - Required: immediately ld_ready=1 and cpu_rst=1. Reloading 1 word with ld_last restarts the sequence at ld_ptr=0.

Source files
------------

// File: rtl/cpu_memory_responder.sv
// rtl/cpu_memory_responder.sv - boot loader plus instruction/data memory responder for the pipelined MIPS CPU
module cpu_memory_responder #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Pc,
  output logic [31:0] Inst,
  input  logic [31:0] MemAdr,
  input  logic [31:0] MemWriteData,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  output logic [31:0] MemReadData,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_rst,
  output logic        misalign_err,
  output logic [31:0] err_adr
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IAW-1:0]  ld_ptr_q, ld_ptr_d;
  logic [DAW-1:0]  clr_ptr_q, clr_ptr_d;
  logic            misalign_err_q, misalign_err_d;
  logic [31:0]     err_adr_q, err_adr_d;

  logic [31:0]     imem [IMEM_WORDS];
  logic [31:0]     dmem [DMEM_WORDS];

  logic            run;
  logic            aligned;
  logic            misaligned;
  logic            store_en;
  logic            ld_fire;
  logic [IAW-1:0]  inst_idx;
  logic [DAW-1:0]  data_idx;
  logic            unused_addr_bits;

  assign run        = (state_q == ST_RUN);
  assign aligned    = (MemAdr[1:0] == 2'b00);
  assign misaligned = run && (MemoryRead || MemoryWrite) && !aligned;
  assign store_en   = run && MemoryWrite && aligned;
  // A word is only taken while reset is released, so a loader held valid during reset writes nothing.
  assign ld_fire    = (state_q == ST_LOAD) && ld_valid && rst;
  assign inst_idx   = Pc[2 +: IAW];
  assign data_idx   = MemAdr[2 +: DAW];

  // Upper address bits alias and the byte offset of Pc is don't-care.
  assign unused_addr_bits = ^{Pc[31:IAW+2], Pc[1:0], MemAdr[31:DAW+2]};

  // Boot sequencer next state, pointers, and state-decoded handshake/reset outputs.
  always_comb begin
    state_d   = state_q;
    ld_ptr_d  = ld_ptr_q;
    clr_ptr_d = clr_ptr_q;
    ld_ready  = 1'b0;
    cpu_rst   = 1'b1;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ld_ptr_d = ld_ptr_q + IAW'(1);
          if (ld_last || (ld_ptr_q == IAW'(IMEM_WORDS - 1))) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
          end
        end
      end
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + DAW'(1);
        if (clr_ptr_q == DAW'(DMEM_WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Sticky misalignment flag; only the first offending address is captured.
  always_comb begin
    misalign_err_d = misalign_err_q;
    err_adr_d      = err_adr_q;
    if (misaligned) begin
      misalign_err_d = 1'b1;
      if (!misalign_err_q) begin
        err_adr_d = MemAdr;
      end
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_LOAD;
      ld_ptr_q       <= '0;
      clr_ptr_q      <= '0;
      misalign_err_q <= 1'b0;
      err_adr_q      <= '0;
    end else begin
      state_q        <= state_d;
      ld_ptr_q       <= ld_ptr_d;
      clr_ptr_q      <= clr_ptr_d;
      misalign_err_q <= misalign_err_d;
      err_adr_q      <= err_adr_d;
    end
  end

  // Instruction memory is written only by the loader; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      imem[ld_ptr_q] <= ld_data;
    end
  end

  // Data memory: zero-fill during CLEAR, aligned CPU stores during RUN.
  always_ff @(posedge clk) begin
    if ((state_q == ST_CLEAR) && rst) begin
      dmem[clr_ptr_q] <= '0;
    end else if (store_en && rst) begin
      dmem[data_idx] <= MemWriteData;
    end
  end

  assign Inst         = run ? imem[inst_idx] : '0;
  assign MemReadData  = (run && MemoryRead && aligned) ? dmem[data_idx] : '0;
  assign misalign_err = misalign_err_q;
  assign err_adr      = err_adr_q;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// tb/tb_cpu_memory_responder.sv - self-checking bench for cpu_memory_responder
module tb_cpu_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Pc;
  logic [31:0] Inst;
  logic [31:0] MemAdr;
  logic [31:0] MemWriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [31:0] MemReadData;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic        misalign_err;
  logic [31:0] err_adr;

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_memory_responder #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .Pc(Pc), .Inst(Inst),
    .MemAdr(MemAdr), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .MemReadData(MemReadData),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_rst(cpu_rst), .misalign_err(misalign_err), .err_adr(err_adr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Present one loader word at a negedge; it is accepted at the following posedge.
  task automatic push_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Count edges after the last acceptance until cpu_rst drops, watching ld_ready.
  task automatic wait_release(output int cycles, output logic saw_ready);
    cycles    = 0;
    saw_ready = 1'b0;
    while (cpu_rst === 1'b1 && cycles < 1000) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (ld_ready !== 1'b0) saw_ready = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic saw;
    exp_t e;

    vecs[0] = '{1'b0, 1'b0, 32'h0,         32'h0,        32'h0,        32'h20080005, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,         32'h0,        32'h4,        32'h20090007, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h20,        32'h0,        32'h8,        32'h01095020, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h10,        32'hDEADBEEF, 32'hC,        32'hAC0A0000, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h10,        32'h0,        32'h408,      32'h01095020, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h410,       32'h0,        32'hB,        32'h01095020, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b1, 32'h10,        32'h11,       32'h0,        32'h20080005, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 32'h10,        32'h22,       32'h4,        32'h20090007, 32'h11};
    vecs[8] = '{1'b1, 1'b0, 32'h10,        32'h0,        32'h1000000C, 32'hAC0A0000, 32'h22};
    vecs[9] = '{1'b1, 1'b0, 32'h14,        32'h0,        32'h0,        32'h20080005, 32'h0};

    rst = 1'b0; Pc = '0; MemAdr = '0; MemWriteData = '0;
    MemoryRead = 1'b0; MemoryWrite = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    #12;
    check("reset ld_ready", ld_ready, 1);
    check("reset cpu_rst", cpu_rst, 1);
    check("reset Inst", Inst, 0);
    check("reset MemReadData", MemReadData, 0);
    check("reset misalign_err", misalign_err, 0);
    check("reset err_adr", err_adr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    push_word(32'h20080005, 1'b0);
    push_word(32'h20090007, 1'b0);
    push_word(32'h01095020, 1'b0);
    push_word(32'hAC0A0000, 1'b1);
    check("clear ld_ready", ld_ready, 0);
    wait_release(cyc, saw);
    check("release latency", cyc, 256);
    check("ld_ready during clear", saw, 0);

    for (int i = 0; i < 10; i++) begin
      Pc = vecs[i].pc;
      MemAdr = vecs[i].adr;
      MemWriteData = vecs[i].wdata;
      MemoryRead = vecs[i].rd;
      MemoryWrite = vecs[i].wr;
      ld_valid = 1'b1;
      ld_data = 32'hFFFFFFFF;
      ld_last = 1'b1;
      sb.push_back('{vecs[i].exp_inst, vecs[i].exp_rdata});
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d Inst", i), Inst, e.inst);
      check($sformatf("vec%0d MemReadData", i), MemReadData, e.rdata);
      check($sformatf("vec%0d ld_ready", i), ld_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0; MemoryRead = 1'b0; MemoryWrite = 1'b0;
    check("no error yet", misalign_err, 0);

    MemAdr = 32'h12; MemWriteData = 32'h99; MemoryWrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MemoryWrite = 1'b0;
    check("misalign_err after store", misalign_err, 1);
    check("err_adr after store", err_adr, 32'h12);
    MemAdr = 32'h21; MemoryRead = 1'b1;
    #1;
    check("misaligned load data", MemReadData, 0);
    @(posedge clk);
    @(negedge clk);
    check("err_adr kept", err_adr, 32'h12);
    MemAdr = 32'h10;
    #1;
    check("dmem[4] unchanged", MemReadData, 32'h22);
    MemoryRead = 1'b0;

    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst cpu_rst", cpu_rst, 1);
    check("async rst ld_ready", ld_ready, 1);
    check("async rst misalign_err", misalign_err, 0);
    check("async rst err_adr", err_adr, 0);
    Pc = '0;
    #1;
    check("async rst Inst", Inst, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("ld_ready before full", ld_ready, 1);
      push_word(32'h10000000 + i, 1'b0);
    end
    check("full ld_ready", ld_ready, 0);
    check("full cpu_rst", cpu_rst, 1);
    wait_release(cyc, saw);
    check("full release latency", cyc, 256);
    check("full ld_ready stays low", saw, 0);
    Pc = 32'h0;
    #1;
    check("full Inst[0]", Inst, 32'h10000000);
    Pc = 32'h3FC;
    #1;
    check("full Inst[255]", Inst, 32'h100000FF);

    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_word(32'hCAFEF00D, 1'b1);
    repeat (9) @(negedge clk);
    Pc = 32'h0; MemAdr = 32'h11; MemoryRead = 1'b1;
    #1;
    check("clear Inst gated", Inst, 0);
    check("clear MemReadData gated", MemReadData, 0);
    @(posedge clk);
    @(negedge clk);
    MemoryRead = 1'b0;
    check("clear ignores misalign", misalign_err, 0);
    #2 rst = 1'b0;
    #1;
    check("mid-clear ld_ready", ld_ready, 1);
    check("mid-clear cpu_rst", cpu_rst, 1);
    @(negedge clk);
    rst = 1'b1;
    push_word(32'h12345678, 1'b1);
    wait_release(cyc, saw);
    check("reload release latency", cyc, 256);
    Pc = 32'h0;
    #1;
    check("reload Inst[0]", Inst, 32'h12345678);
    Pc = 32'h4;
    #1;
    check("reload Inst[1] kept", Inst, 32'h10000001);
    MemAdr = 32'h10; MemoryRead = 1'b1;
    #1;
    check("reload dmem cleared", MemReadData, 0);
    MemoryRead = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
